// File: rtl/sine_checksum_pkg.sv
// Shared types and default parameter values for the sine checksum engine.
package sine_checksum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_COMPARE
  } state_t;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_RES_W       = 32;
  localparam int DEF_N_SAMPLES   = 256;
  localparam int DEF_ACC_W       = 40;
  localparam int DEF_BRAM_LAT    = 1;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/checksum_valid_delay.sv
// Shift register that delays the BRAM enable by LAT cycles so that the phase
// valid lines up with the read data coming back from the BRAM.
module checksum_valid_delay #(
  parameter int LAT = 1
) (
  input  logic CLK100MHZ,
  input  logic reset_in,
  input  logic mem_en,
  output logic phase_valid
);

  logic [LAT-1:0] pipe;

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      pipe <= '0;
    end else begin
      pipe[0] <= mem_en;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign phase_valid = pipe[LAT-1];

endmodule

// File: rtl/sine_checksum_engine.sv
// Streams N_SAMPLES phases from BRAM into a CORDIC and sums the sine results.
// Optional DRAIN watchdog enabled by defining CHECKSUM_TIMEOUT_EN.
module sine_checksum_engine
  import sine_checksum_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RES_W     = DEF_RES_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int BRAM_LAT  = DEF_BRAM_LAT
`ifdef CHECKSUM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic               CLK100MHZ,
  input  logic               reset_in,
  input  logic               start,
  input  logic [ACC_W-1:0]   expected,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               s_axis_phase_tvalid,
  output logic [DATA_W-1:0]  s_axis_phase_tdata,
  input  logic               m_axis_dout_tvalid,
  input  logic [2*RES_W-1:0] m_axis_dout_tdata,
  output logic               busy,
  output logic               done,
  output logic               success,
  output logic               error,
  output logic [ACC_W-1:0]   sum_out
);

  // One extra bit so the counters can represent N_SAMPLES itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        addr_cnt, res_cnt;
  logic [ACC_W-1:0]        acc, expected_q;
  logic signed [RES_W-1:0] sine_val;
  logic                    start_ok, res_accept, res_all;
  logic                    timeout_hit, timed_out;

  assign sine_val   = m_axis_dout_tdata[2*RES_W-1:RES_W];
  assign start_ok   = start && (state == ST_IDLE);
  assign res_accept = m_axis_dout_tvalid && (res_cnt < N_CNT) &&
                      ((state == ST_STREAM) || (state == ST_DRAIN));
  assign res_all    = (res_cnt == N_CNT) || (res_accept && (res_cnt == LAST_IDX));

  assign mem_addr           = mem_en ? addr_cnt[ADDR_W-1:0] : '0;
  assign s_axis_phase_tdata = s_axis_phase_tvalid ? mem_rdata : '0;

  checksum_valid_delay #(
    .LAT(BRAM_LAT)
  ) u_valid_delay (
    .CLK100MHZ  (CLK100MHZ),
    .reset_in   (reset_in),
    .mem_en     (mem_en),
    .phase_valid(s_axis_phase_tvalid)
  );

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        mem_en = 1'b1;
        if (addr_cnt == LAST_IDX) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_all || timeout_hit) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      addr_cnt   <= '0;
      res_cnt    <= '0;
      acc        <= '0;
      expected_q <= '0;
      sum_out    <= '0;
      success    <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        addr_cnt   <= '0;
        res_cnt    <= '0;
        acc        <= '0;
        expected_q <= expected;
        success    <= 1'b0;
        error      <= 1'b0;
      end else begin
        if (mem_en) addr_cnt <= addr_cnt + 1'b1;
        // Sign-extended sine half; wraps modulo 2^ACC_W by construction.
        if (res_accept) begin
          res_cnt <= res_cnt + 1'b1;
          acc     <= acc + ACC_W'(sine_val);
        end
      end
      if (state == ST_COMPARE) begin
        sum_out <= acc;
        success <= (acc == expected_q) && !timed_out;
        error   <= (acc != expected_q) || timed_out;
      end
    end
  end

`ifdef CHECKSUM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timed_out_q;

  assign timeout_hit = (state == ST_DRAIN) && !res_all &&
                       (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign timed_out   = timed_out_q;

  // Watchdog restarts on every accepted result and only runs while draining.
  always_ff @(posedge CLK100MHZ) begin
    if (reset_in || start_ok) begin
      wd_cnt      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if ((state != ST_DRAIN) || res_accept) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit) timed_out_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

endmodule

// File: tb/tb_sine_checksum_engine.sv
// Randomized bench for sine_checksum_engine with BRAM and CORDIC models and a
// plain-arithmetic checksum reference.
module tb_sine_checksum_engine;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int RES_W      = 16;
  localparam int N          = 8;
  localparam int ACC_W      = 17;
  localparam int BRAM_LAT   = 2;
  localparam int CORDIC_LAT = 3;
  localparam int LATENCY    = N + BRAM_LAT + CORDIC_LAT + 1;
`ifdef CHECKSUM_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 64;
`endif

  logic               CLK100MHZ = 1'b0;
  logic               reset_in;
  logic               start;
  logic [ACC_W-1:0]   expected;
  logic               mem_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic               s_axis_phase_tvalid;
  logic [DATA_W-1:0]  s_axis_phase_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*RES_W-1:0] m_axis_dout_tdata;
  logic               busy, done, success, error;
  logic [ACC_W-1:0]   sum_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  sine_checksum_engine #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RES_W    (RES_W),
    .N_SAMPLES(N),
    .ACC_W    (ACC_W),
    .BRAM_LAT (BRAM_LAT)
`ifdef CHECKSUM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) dut (
    .CLK100MHZ          (CLK100MHZ),
    .reset_in           (reset_in),
    .start              (start),
    .expected           (expected),
    .mem_en             (mem_en),
    .mem_addr           (mem_addr),
    .mem_rdata          (mem_rdata),
    .s_axis_phase_tvalid(s_axis_phase_tvalid),
    .s_axis_phase_tdata (s_axis_phase_tdata),
    .m_axis_dout_tvalid (m_axis_dout_tvalid),
    .m_axis_dout_tdata  (m_axis_dout_tdata),
    .busy               (busy),
    .done               (done),
    .success            (success),
    .error              (error),
    .sum_out            (sum_out)
  );

  // BRAM and CORDIC behavioural models (fixed pipelines, sine from a table).
  logic [DATA_W-1:0]       mem_model [2**ADDR_W];
  logic signed [RES_W-1:0] sine_tab  [256];
  logic [DATA_W-1:0]       bram_pipe [BRAM_LAT];
  logic                    cord_v    [CORDIC_LAT];
  logic [RES_W-1:0]        cord_d    [CORDIC_LAT];
  logic                    model_rst, drop_last, spur_valid;
  int                      ph_idx;

  always @(posedge CLK100MHZ) begin
    if (model_rst) begin
      for (int i = 0; i < BRAM_LAT; i++) bram_pipe[i] <= '0;
      for (int i = 0; i < CORDIC_LAT; i++) begin
        cord_v[i] <= 1'b0;
        cord_d[i] <= '0;
      end
      ph_idx <= 0;
    end else begin
      bram_pipe[0] <= mem_model[mem_addr];
      for (int i = 1; i < BRAM_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
      cord_v[0] <= s_axis_phase_tvalid && !(drop_last && ph_idx == N - 1);
      cord_d[0] <= sine_tab[s_axis_phase_tdata];
      for (int i = 1; i < CORDIC_LAT; i++) begin
        cord_v[i] <= cord_v[i-1];
        cord_d[i] <= cord_d[i-1];
      end
      if (!busy) ph_idx <= 0;
      else if (s_axis_phase_tvalid) ph_idx <= ph_idx + 1;
    end
  end

  assign mem_rdata          = bram_pipe[BRAM_LAT-1];
  assign m_axis_dout_tvalid = cord_v[CORDIC_LAT-1] | spur_valid;
  assign m_axis_dout_tdata  = cord_v[CORDIC_LAT-1] ? {cord_d[CORDIC_LAT-1], 16'hA5C3}
                                                   : {16'h4321, 16'h5AA5};

  // Monitor sampled on the falling edge.
  int cyc = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
  int addr_q[$];

  always @(negedge CLK100MHZ) begin
    cyc++;
    if (mem_en) addr_q.push_back(int'(mem_addr));
    if (start && !busy && !reset_in) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [ACC_W-1:0] ref_sum(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(sine_tab[mem_model[i]]);
    return ACC_W'(s);
  endfunction

  function automatic bit addrs_ok();
    if (addr_q.size() != N) return 1'b0;
    for (int i = 0; i < N; i++) if (addr_q[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2**ADDR_W; i++) mem_model[i] = DATA_W'($urandom);
    for (int i = 0; i < 256; i++) sine_tab[i] = RES_W'($urandom);
  endtask

  task automatic fill_const(input logic [DATA_W-1:0] m, input logic [RES_W-1:0] s);
    for (int i = 0; i < 2**ADDR_W; i++) mem_model[i] = m;
    for (int i = 0; i < 256; i++) sine_tab[i] = s;
  endtask

  task automatic launch(input logic [ACC_W-1:0] exp_val);
    done_cnt = 0;
    addr_q.delete();
    expected = exp_val;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done_cnt > 0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    fill_const('0, '0);
    repeat (3) tick();
    n_checks++;
    if ({busy, done, success, error, mem_en, s_axis_phase_tvalid} !== 6'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy, done, success, error, mem_en, s_axis_phase_tvalid});
    end
    n_checks++;
    if (mem_addr !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_addr: got %0h expected 0", mem_addr);
    end
    n_checks++;
    if (sum_out !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_sum: got %0h expected 0", sum_out);
    end
    n_checks++;
    if (s_axis_phase_tdata !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_phase: got %0h expected 0", s_axis_phase_tdata);
    end
    reset_in  = 1'b0;
    model_rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    bit got;
    fill_const('0, '0);
    launch('0);
    wait_done(LATENCY + 20, got);
    repeat (3) tick();
    n_checks++;
    if (!got || done_cnt != 1) begin
      n_errors++;
      $display("[TB] FAIL zero_done: got %0d pulses expected 1", done_cnt);
    end
    n_checks++;
    if ({success, error} !== 2'b10 || sum_out !== '0) begin
      n_errors++;
      $display("[TB] FAIL zero_verdict: got s=%b e=%b sum=%0h expected s=1 e=0 sum=0",
               success, error, sum_out);
    end
    n_checks++;
    if (done_cyc - start_cyc != LATENCY) begin
      n_errors++;
      $display("[TB] FAIL zero_latency: got %0d expected %0d", done_cyc - start_cyc, LATENCY);
    end
  endtask

  task automatic test_known();
    bit got;
    fill_const('0, '0);
    for (int i = 0; i < 4; i++) mem_model[i] = DATA_W'(i + 1);
    sine_tab[1] = 16'sd100;
    sine_tab[2] = -16'sd50;
    sine_tab[3] = 16'sd25;
    sine_tab[4] = -16'sd75;
    launch('0);
    wait_done(LATENCY + 20, got);
    n_checks++;
    if (!got || {success, error} !== 2'b10 || sum_out !== '0) begin
      n_errors++;
      $display("[TB] FAIL known_match: got s=%b e=%b sum=%0h expected s=1 e=0 sum=0",
               success, error, sum_out);
    end
    launch(17'd1);
    wait_done(LATENCY + 20, got);
    n_checks++;
    if (!got || {success, error} !== 2'b01) begin
      n_errors++;
      $display("[TB] FAIL known_mismatch: got s=%b e=%b expected s=0 e=1", success, error);
    end
  endtask

  task automatic test_random();
    bit got, match;
    logic [ACC_W-1:0] ref_val, exp_in;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      ref_val = ref_sum(N);
      match   = 1'($urandom_range(0, 1));
      exp_in  = match ? ref_val : ref_val ^ (ACC_W'(1) << $urandom_range(0, ACC_W - 1));
      launch(exp_in);
      wait_done(LATENCY + 20, got);
      n_checks++;
      if (!got || sum_out !== ref_val) begin
        n_errors++;
        $display("[TB] FAIL random_sum[%0d]: got %0h expected %0h", it, sum_out, ref_val);
      end
      n_checks++;
      if ({success, error} !== {match, !match}) begin
        n_errors++;
        $display("[TB] FAIL random_verdict[%0d]: got s=%b e=%b expected s=%b e=%b",
                 it, success, error, match, !match);
      end
      n_checks++;
      if (!addrs_ok() || done_cyc - start_cyc != LATENCY) begin
        n_errors++;
        $display("[TB] FAIL random_addr_lat[%0d]: got %0d addrs lat %0d expected %0d addrs lat %0d",
                 it, addr_q.size(), done_cyc - start_cyc, N, LATENCY);
      end
    end
  endtask

  task automatic test_wrap();
    bit got;
    fill_random();
    for (int i = 0; i < 256; i++) sine_tab[i] = 16'sh7FFF;
    launch(17'h1FFF8);
    wait_done(LATENCY + 20, got);
    n_checks++;
    if (!got || sum_out !== 17'h1FFF8 || success !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL wrap_pos: got sum=%0h s=%b expected sum=1fff8 s=1", sum_out, success);
    end
    for (int i = 0; i < 256; i++) sine_tab[i] = 16'sh8000;
    launch('0);
    wait_done(LATENCY + 20, got);
    n_checks++;
    if (!got || sum_out !== '0 || success !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL wrap_neg: got sum=%0h s=%b expected sum=0 s=1", sum_out, success);
    end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] ref_val;
    fill_random();
    ref_val = ref_sum(N);
    launch(ref_val);
    for (int i = 0; i < LATENCY + 10; i++) begin
      tick();
      start = (i == 2) || (i == 8) || done;
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL restart_ignored: got %0d pulses busy=%b expected 1 pulse busy=0",
               done_cnt, busy);
    end
    n_checks++;
    if (!addrs_ok() || sum_out !== ref_val || success !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL restart_result: got %0d addrs sum=%0h expected %0d addrs sum=%0h",
               addr_q.size(), sum_out, N, ref_val);
    end
  endtask

  task automatic test_spurious();
    bit got;
    logic [ACC_W-1:0] ref_val;
    spur_valid = 1'b1;
    repeat (5) tick();
    spur_valid = 1'b0;
    fill_random();
    ref_val = ref_sum(N);
    launch(ref_val);
    wait_done(LATENCY + 20, got);
    n_checks++;
    if (!got || sum_out !== ref_val || success !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL idle_results: got sum=%0h s=%b expected sum=%0h s=1",
               sum_out, success, ref_val);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [ACC_W-1:0] ref_val;
    fill_random();
    launch(ref_sum(N));
    repeat (9) tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    n_checks++;
    if ({busy, success, error} !== 3'b000 || sum_out !== '0) begin
      n_errors++;
      $display("[TB] FAIL abort_state: got b=%b s=%b e=%b sum=%0h expected all 0",
               busy, success, error, sum_out);
    end
    repeat (20) tick();
    n_checks++;
    if (done_cnt != 0 || {success, error} !== 2'b00) begin
      n_errors++;
      $display("[TB] FAIL abort_no_done: got %0d pulses s=%b e=%b expected 0 pulses",
               done_cnt, success, error);
    end
    reset_in = 1'b1;
    start    = 1'b1;
    tick();
    reset_in = 1'b0;
    start    = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_over_start: got busy=%b expected 0", busy);
    end
    fill_random();
    ref_val = ref_sum(N);
    launch(ref_val);
    wait_done(LATENCY + 20, got);
    n_checks++;
    if (!got || sum_out !== ref_val || {success, error} !== 2'b10) begin
      n_errors++;
      $display("[TB] FAIL rerun: got sum=%0h s=%b e=%b expected sum=%0h s=1 e=0",
               sum_out, success, error, ref_val);
    end
  endtask

  task automatic test_timeout();
    logic [ACC_W-1:0] partial;
    fill_random();
    partial   = ref_sum(N - 1);
    drop_last = 1'b1;
    launch(ref_sum(N));
`ifdef CHECKSUM_TIMEOUT_EN
    begin
      bit got;
      wait_done(LATENCY + TIMEOUT_CYC + 40, got);
      n_checks++;
      if (!got || {success, error} !== 2'b01 || sum_out !== partial) begin
        n_errors++;
        $display("[TB] FAIL timeout: got done=%b s=%b e=%b sum=%0h expected s=0 e=1 sum=%0h",
                 got, success, error, sum_out, partial);
      end
      n_checks++;
      if (done_cyc - start_cyc < TIMEOUT_CYC) begin
        n_errors++;
        $display("[TB] FAIL timeout_delay: got %0d expected at least %0d",
                 done_cyc - start_cyc, TIMEOUT_CYC);
      end
    end
`else
    repeat (200) tick();
    n_checks++;
    if (busy !== 1'b1 || done_cnt != 0) begin
      n_errors++;
      $display("[TB] FAIL drain_wait: got busy=%b pulses=%0d expected busy=1 pulses=0 (partial %0h)",
               busy, done_cnt, partial);
    end
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
`endif
    drop_last = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset_in   = 1'b1;
    model_rst  = 1'b1;
    start      = 1'b0;
    expected   = '0;
    spur_valid = 1'b0;
    drop_last  = 1'b0;
    test_reset();
    test_zero();
    test_known();
    test_random();
    test_wrap();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/sine_checksum_engine.md
SINE_CHECKSUM_ENGINE -- requirements
Module: sine_checksum_engine

Interface
REQ-001 Parameter ADDR_W, default 8, BRAM address width.
REQ-002 Parameter DATA_W, default 8, sample/phase width.
REQ-003 Parameter RES_W, default 32, width of one CORDIC output half (sine = upper half).
REQ-004 Parameter N_SAMPLES, default 256, samples per run, 1..2^ADDR_W.
REQ-005 Parameter ACC_W, default 40, accumulator width, >= RES_W.
REQ-006 Parameter BRAM_LAT, default 1, BRAM read latency in cycles, 1..3.
REQ-007 CLK100MHZ  in  1  sole clock, all logic on rising edge.
REQ-008 reset_in  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle run request, already debounced and edge-detected.
REQ-010 expected  in  ACC_W  reference checksum, sampled at accepted start.
REQ-011 mem_en / mem_addr  out  1 / ADDR_W  BRAM port A enable and address.
REQ-012 mem_rdata  in  DATA_W  BRAM read data.
REQ-013 s_axis_phase_tvalid / s_axis_phase_tdata  out  1 / DATA_W  phase to CORDIC.
REQ-014 m_axis_dout_tvalid / m_axis_dout_tdata  in  1 / 2*RES_W  CORDIC result.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  one-cycle pulse at end of run.
REQ-017 success / error  out  1 / 1  verdict, held until next accepted start or reset.
REQ-018 sum_out  out  ACC_W  final checksum, held with verdict.

Function
REQ-019 FSM states IDLE, STREAM, DRAIN, COMPARE; IDLE -> STREAM on start; STREAM -> DRAIN after N_SAMPLES addresses issued; DRAIN -> COMPARE when N_SAMPLES results received; COMPARE -> IDLE after one cycle.
REQ-020 Accepted start clears accumulator, counters, success, error; registers expected.
REQ-021 STREAM: mem_en=1, mem_addr 0..N_SAMPLES-1, one address per cycle, no gaps.
REQ-022 Phase valid = mem_en delayed BRAM_LAT cycles; s_axis_phase_tdata = mem_rdata in that cycle (no added register).
REQ-023 Each cycle m_axis_dout_tvalid=1 in STREAM or DRAIN: acc += sign-extended tdata[2*RES_W-1:RES_W], result count +1.
REQ-024 Accumulation is modulo 2^ACC_W; overflow wraps silently.
REQ-025 m_axis_dout_tvalid outside STREAM/DRAIN ignored; results beyond N_SAMPLES in a run ignored.
REQ-026 COMPARE: sum_out<=acc; success<=(acc==expected); error<=(acc!=expected); done=1 for that cycle.
REQ-027 start while busy ignored; start in COMPARE ignored.
REQ-028 busy=1 in STREAM, DRAIN, COMPARE.
REQ-029 Start-to-done latency = N_SAMPLES + BRAM_LAT + CORDIC latency + 1 cycles.
REQ-030 N_SAMPLES=1: single address 0, STREAM lasts one cycle.

Reset
REQ-031 reset_in=1: state IDLE; mem_en, s_axis_phase_tvalid, busy, done, success, error =0; mem_addr, s_axis_phase_tdata, sum_out, accumulator, counters =0.
REQ-032 reset_in mid-run aborts: no done pulse, no verdict, late CORDIC results ignored per REQ-025.
REQ-033 reset_in overrides start in the same cycle.

Configuration
REQ-034 Macro CHECKSUM_TIMEOUT_EN defined: watchdog in DRAIN counts cycles since last result; reaching parameter TIMEOUT_CYC (default 1024) -> COMPARE with error=1, success=0, sum_out=partial acc, done pulsed.
REQ-035 CHECKSUM_TIMEOUT_EN undefined: no watchdog; DRAIN waits indefinitely; TIMEOUT_CYC unused.

Structure
REQ-036 Package sine_checksum_pkg holds the FSM state enum and default parameter constants.
REQ-037 One sub-module, checksum_valid_delay: parametrised BRAM_LAT-stage shift register aligning valid to read data.

Verification
REQ-038 Defaults, BRAM=0x00 all, CORDIC model sine=0, expected=0 -> done once, success=1, sum_out=0.
REQ-039 N_SAMPLES=4, sines 100,-50,25,-75, expected=0 -> success=1, sum_out=0; expected=1 -> error=1.
REQ-040 ACC_W=32, N_SAMPLES=2, sines 0x7FFFFFFF twice -> sum_out=0xFFFFFFFE (wrap), success iff expected equal.
REQ-041 start pulsed again mid-STREAM and in COMPARE -> ignored, exactly one done, addresses 0..N-1 once each.
REQ-042 reset_in at cycle 10 of run, then new start -> no done from first run, second run verdict correct.
REQ-043 CHECKSUM_TIMEOUT_EN, CORDIC model drops last result -> done after TIMEOUT_CYC cycles, error=1; without macro busy stays 1.
